serial_pair_serializer_msb_first: RTL and testbench
===================================================

# serial_pair_serializer_msb_first

Parallel-to-serial front end for the MSB-first serial comparator. It accepts two WIDTH-bit operands through a valid/ready handshake and streams them out one bit pair per clock, most significant bit first. Per-word framing strobes (`out_first`, `out_last`) let the downstream comparator restart its state at each word boundary. Words can be issued back to back with no idle cycle between them.

## Interface

**Parameters**
- `WIDTH`, default 8: operand width in bits; legal range ≥ 1.

**Ports**
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `a_in`/`b_in` hold a word to load.
- `in_ready`  out  1: the block can accept a word this cycle.
- `a_in`  in  WIDTH: operand A, parallel.
- `b_in`  in  WIDTH: operand B, parallel.
- `a_out`  out  1: current serial bit of A.
- `b_out`  out  1: current serial bit of B.
- `out_valid`  out  1: `a_out`/`b_out` carry a live bit.
- `out_first`  out  1: the current bit is the MSB (bit WIDTH-1) of a word.
- `out_last`  out  1: the current bit is the LSB (bit 0) of a word.

## Operation

- **State:** two WIDTH-bit shift registers (A, B), a down-counter `cnt` of width $clog2(WIDTH+1), and an `active` flag. The FSM has two states:
  - IDLE (`active`=0)
  - SHIFT (`active`=1)
- **Accept:** a word is accepted when `in_valid & in_ready` is high on a clock edge.
- **`in_ready`** is combinational from registered state only, never from `in_valid`:
  - `in_ready = ~active | (cnt == 1)`.
  - A word can be accepted while idle, or during the cycle that emits the LSB of the current word.
- **IDLE, on accept:**
  - Load the shift registers with `a_in`/`b_in`.
  - Set `cnt = WIDTH` and `active = 1`.
  - Set `out_first` = 1 for the next cycle.
- **SHIFT, each cycle:**
  - Outputs are A[WIDTH-1] and B[WIDTH-1].
  - Shift registers shift left by 1, filling zeros.
  - `cnt` decrements.
  - `out_first` = 1 only for the first output cycle of a word.
  - `out_last` = (`cnt` == 1).
- **End of word (`cnt` == 1):**
  - If a word is accepted in that cycle: reload, set `cnt = WIDTH`, stay in SHIFT, and assert `out_first` in the next cycle.
  - Otherwise: go to IDLE.
- **Idle outputs:** `out_valid` = 0, and `a_out`, `b_out`, `out_first`, `out_last` all = 0.
- **`out_valid`** = `active`.
- **WIDTH = 1:** `out_first` and `out_last` are both 1 on every emitted bit. `in_ready` stays 1 whenever active, so words stream once per cycle.
- **No output backpressure.** The consumer takes one bit pair every cycle that `out_valid` = 1.
- **Inputs outside an accept cycle** have no effect. `a_in`/`b_in` are sampled only on the accept edge.

## Timing

- **Reset:**
  - While `rst` = 1 at an edge: `active` = 0, `cnt` = 0, shift registers = 0. No word is accepted even if `in_valid` = 1.
  - After that edge, every output is 0 except `in_ready` = 1.
- **Latency:** a word accepted at edge T has its MSB visible in the cycle after T, with `out_first` = 1. Bit i is visible in cycle T + (WIDTH − i). The LSB is visible in cycle T + WIDTH, with `out_last` = 1.
- **Back-to-back:** an accept at the edge that ends the LSB cycle puts the next word's MSB in the immediately following cycle. Bits appear with no bubble, and `out_valid` stays 1.
- **Throughput:** one word per WIDTH cycles, sustained.
- **Reset mid-word:** the word is discarded. Outputs are 0 in the cycle after the reset edge, and no `out_last` is emitted for the truncated word. The downstream comparator is reset by the same `rst`.
- **Simultaneous `rst` and accept:** reset wins and the word is dropped.

## Test plan

- **Single word:** WIDTH=8, `a_in`=8'hA5, `b_in`=8'hA4, accepted at edge T.
  - `a_out` must read 1,0,1,0,0,1,0,1 and `b_out` must read 1,0,1,0,0,1,0,0 in cycles T+1..T+8.
  - `out_first` = 1 only at T+1, `out_last` = 1 only at T+8.
  - `out_valid` = 0 at T+9, and `in_ready` = 1 at T+9.
- **Back-to-back:** `in_valid` held high with 8'h0F/8'hF0, then 8'hFF/8'hFF.
  - The second word is accepted during the first word's LSB cycle (`in_ready` = 1 there, 0 in the 7 cycles before).
  - 16 contiguous valid cycles.
  - `out_first` at cycles 1 and 9, `out_last` at cycles 8 and 16.
- **Gap:** `in_valid` low for 3 cycles between words.
  - `out_valid` = 0 and all data/strobe outputs = 0 during the idle cycles.
  - The next word starts with `out_first` = 1.
- **Reset mid-word:** assert `rst` for 1 cycle after 3 bits of 8'h81/8'h80.
  - All outputs 0 except `in_ready` = 1 in the next cycle.
  - No `out_last` for the truncated word.
  - A fresh word after reset serializes correctly.
- **Reset with `in_valid` = 1:** no accept occurs, and `out_valid` stays 0.
- **WIDTH=1 instance:** stream 1/0, 0/1, 1/1 with `in_valid` held high.
  - Outputs in three consecutive cycles, each with `out_first` = `out_last` = 1.
  - `in_ready` stays 1 throughout.

Source files
------------

// File: rtl/serial_pair_serializer_msb_first.sv
// Parallel-to-serial front end: loads two WIDTH-bit operands and streams them
// out MSB first, one bit pair per clock, with per-word first/last strobes.
module serial_pair_serializer_msb_first #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             a_out,
   output logic             b_out,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             first_q, first_d;
   logic             active;
   logic             at_lsb;
   logic             accept;

   assign active   = (state_q == SHIFT);
   assign at_lsb   = (cnt_q == CW'(1));
   // Ready depends on registered state only, so a new word can land on the LSB cycle.
   assign in_ready = ~active | at_lsb;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      if (accept) begin
         state_d = SHIFT;
         a_d     = a_in;
         b_d     = b_in;
         cnt_d   = CW'(WIDTH);
         first_d = 1'b1;
      end else if (active) begin
         a_d     = a_q << 1;
         b_d     = b_q << 1;
         cnt_d   = cnt_q - CW'(1);
         first_d = 1'b0;
         if (at_lsb) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   // Gate everything with active so idle cycles present clean zeros downstream.
   assign out_valid = active;
   assign a_out     = active & a_q[WIDTH-1];
   assign b_out     = active & b_q[WIDTH-1];
   assign out_first = active & first_q;
   assign out_last  = active & at_lsb;

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Scoreboard bench for the MSB-first pair serializer, WIDTH=8 and WIDTH=1 instances.
module tb_serial_pair_serializer_msb_first;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       v8, rdy8, a8o, b8o, ov8, f8, l8;
   logic [7:0] a8i, b8i;
   logic       v1, rdy1, a1o, b1o, ov1, f1, l1;
   logic [0:0] a1i, b1i;

   serial_pair_serializer_msb_first #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a_in(a8i), .b_in(b8i),
      .a_out(a8o), .b_out(b8o), .out_valid(ov8), .out_first(f8), .out_last(l8));

   serial_pair_serializer_msb_first #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .a_in(a1i), .b_in(b1i),
      .a_out(a1o), .b_out(b1o), .out_valid(ov1), .out_first(f1), .out_last(l1));

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;

   // Each entry: {first, last, a, b} expected for one output cycle.
   logic [3:0] q8[$];
   logic [3:0] q1[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: accept when idle or after the last queued bit has been consumed.
   always @(posedge clk) begin
      if (rst) begin
         q8.delete();
         q1.delete();
      end else begin
         if (v8 && q8.size() == 0)
            for (int i = 7; i >= 0; i--)
               q8.push_back({i == 7, i == 0, a8i[i], b8i[i]});
         if (v1 && q1.size() == 0)
            q1.push_back({1'b1, 1'b1, a1i[0], b1i[0]});
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      if (mon_en) begin
         check("w8_valid", 32'(ov8), 32'(q8.size() != 0));
         check("w8_ready", 32'(rdy8), 32'(q8.size() <= 1));
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check("w8_bits", 32'({f8, l8, a8o, b8o}), 32'(e));
         end else begin
            check("w8_idle", 32'({f8, l8, a8o, b8o}), 32'd0);
         end
         check("w1_valid", 32'(ov1), 32'(q1.size() != 0));
         check("w1_ready", 32'(rdy1), 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("w1_bits", 32'({f1, l1, a1o, b1o}), 32'(e));
         end else begin
            check("w1_idle", 32'({f1, l1, a1o, b1o}), 32'd0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b);
      int budget;
      budget = 50;
      v8 = 1'b1; a8i = a; b8i = b;
      while (!rdy8 && budget > 0) begin
         step(1);
         budget--;
      end
      check("w8_accept_timeout", 32'(budget > 0), 32'd1);
      step(1);
   endtask

   task automatic send1(input logic a, input logic b);
      int budget;
      budget = 20;
      v1 = 1'b1; a1i = a; b1i = b;
      while (!rdy1 && budget > 0) begin
         step(1);
         budget--;
      end
      check("w1_accept_timeout", 32'(budget > 0), 32'd1);
      step(1);
   endtask

   initial begin
      rst = 1'b1;
      v8 = 1'b0; a8i = '0; b8i = '0;
      v1 = 1'b0; a1i = '0; b1i = '0;
      step(1);
      mon_en = 1'b1;
      step(1);
      // Reset held while a word is offered: nothing may be accepted.
      v8 = 1'b1; a8i = 8'hFF; b8i = 8'hFF;
      step(1);
      v8 = 1'b0;
      rst = 1'b0;
      step(2);

      send8(8'hA5, 8'hA4);
      v8 = 1'b0;
      step(10);

      send8(8'h0F, 8'hF0);
      send8(8'hFF, 8'hFF);
      v8 = 1'b0;
      step(10);

      send8(8'h3C, 8'hC3);
      v8 = 1'b0;
      step(11);
      send8(8'h96, 8'h69);
      v8 = 1'b0;
      step(10);

      send8(8'h81, 8'h80);
      v8 = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      send8(8'h5A, 8'hC6);
      v8 = 1'b0;
      step(10);

      send1(1'b1, 1'b0);
      send1(1'b0, 1'b1);
      send1(1'b1, 1'b1);
      v1 = 1'b0;
      step(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
